word_to_byte_unpacker: RTL
==========================

Name: word_to_byte_unpacker

Overview:
- Receives 32-bit words with per-byte valid masks (keep) and emits them as an ordered byte stream, one byte per cycle.
- Exact inverse of the byte-to-word packing used by the CRC stimulus path.
- Sits between the 32-bit datapath and byte-serial consumers: the byte-wise CRC reference engine and the byte-level scoreboards.
- Uses valid/ready handshakes on both sides; reports the length of each packet and flags illegal keep masks.

Parameters:
- DATA_WIDTH, 32: input word width; must be a multiple of BYTE.
- BYTE, 8: output byte width.
- DATA_BYTES, DATA_WIDTH/BYTE: byte lanes per word (derived; do not override).
- LEN_WIDTH, 16: width of the packet byte counter.

Ports:
- i_clk, input, 1: clock.
- i_reset_n, input, 1: synchronous, active-low reset.
- s_word_data, input, DATA_WIDTH: input word. Lane 3 = [31:24] is the first byte; lane 0 = [7:0] is the last.
- s_word_keep, input, DATA_BYTES: keep[i] qualifies lane i.
- s_word_last, input, 1: word is the final word of the packet.
- s_word_valid, input, 1: input word valid.
- s_word_ready, output, 1: unpacker can accept a word.
- m_byte_data, output, BYTE: output byte.
- m_byte_last, output, 1: final byte of the packet.
- m_byte_valid, output, 1: output byte valid.
- m_byte_ready, input, 1: downstream accepts the byte.
- o_pkt_len, output, LEN_WIDTH: byte count of the last completed packet.
- o_pkt_done, output, 1: one-cycle pulse when o_pkt_len updates.
- o_keep_err, output, 1: one-cycle pulse when an illegal word is dropped.

Behaviour:
- Reset (i_reset_n low at a clock edge):
  - m_byte_valid=0, m_byte_data=0, m_byte_last=0.
  - o_pkt_len=0, o_pkt_done=0, o_keep_err=0.
  - Holding register emptied; lane index and byte counter cleared; state IDLE.
  - s_word_ready is low during reset and 1 in the first cycle after it.
  - Reset mid-word discards the partial word and the packet; no m_byte_last is produced.
- Handshakes:
  - A transfer occurs on any edge where valid && ready.
  - m_byte_data and m_byte_last hold stable while m_byte_valid && !m_byte_ready.
  - Once asserted, m_byte_valid is never withdrawn before the byte is accepted.
- States:
  - IDLE: register empty; s_word_ready=1.
    - A legal accepted word moves to SERIAL, with the lane index at lane 3.
    - An illegal accepted word stays in IDLE.
  - SERIAL: m_byte_valid=1; m_byte_data = lane at the current index.
    - On m_byte_ready, step down one lane.
    - After the last kept lane is accepted, go to IDLE, or stay in SERIAL if a new word is accepted in the same cycle.
- s_word_ready = IDLE, or (SERIAL && last kept lane && m_byte_ready). This gives gap-free throughput of 1 byte per cycle.
- Latency: a word accepted at edge N presents its first byte from cycle N+1.
- Legal keep:
  - Words with last=0: 1111 only.
  - Words with last=1: 1111, 1110, 1100 or 1000 (contiguous from lane 3).
  - Anything else, including 0000: the word is consumed and dropped, o_keep_err pulses the next cycle, and the packet byte counter clears.
- m_byte_last=1 only on the last kept lane of a word that had last=1.
- Counter:
  - Increments on each byte handshake.
  - On the m_byte_last handshake: o_pkt_len ← count+1, o_pkt_done pulses the next cycle, and the counter clears.
  - Saturates at all-ones; no wrap.
- Simultaneous events: an accept coinciding with the final-byte handshake is legal. The counter clears and then counts the new word's bytes from 0.

Decomposition:
- Shared package stream_pkg holds:
  - DATA_WIDTH, BYTE, DATA_BYTES;
  - typedef word_t {data, keep, last};
  - function keep_legal(keep, last);
  - function last_lane(keep).
- The CRC testbench package imports the same constants.
- No sub-module is required; the lane mux plus FSM stays in one module of roughly 150–200 lines.

Test Plan:
- Two words, 0x01020304/1111 then 0x05060708/1111/last, m_byte_ready=1 → bytes 01..08 on 8 consecutive cycles, last on 08; o_pkt_len=8 with one o_pkt_done pulse.
- 0xA1A2A3A4/1111, then 0xA5000000/1000/last → A1 A2 A3 A4 A5, last on A5, o_pkt_len=5.
- Packet of case 1 with m_byte_ready toggling 1,0,0,1,... → same 8 bytes, none lost or duplicated; data held stable while stalled; s_word_ready low throughout SERIAL until the final byte.
- Word keep=0101/last → no output bytes, o_keep_err pulses once. Word keep=1100 with last=0 → same result.
- Three full words, the third with last, s_word_valid and m_byte_ready held 1 → 12 contiguous valid cycles with no bubble; o_pkt_len=12.
- i_reset_n low after 2 bytes of case 1 → next cycle m_byte_valid=0 and o_pkt_len=0. A following 4-byte packet then reports o_pkt_len=4.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared 32-bit word / byte-stream definitions used by the unpacker and the CRC stimulus path.
package stream_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int BYTE       = 8;
    localparam int DATA_BYTES = DATA_WIDTH / BYTE;
    localparam int LANE_WIDTH = $clog2(DATA_BYTES);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SERIAL = 1'b1
    } unpack_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [DATA_BYTES-1:0] keep;
        logic                  last;
    } word_t;

    // Non-final words must be full; a final word keeps a contiguous run starting at the top lane.
    function automatic logic keep_legal(input logic [DATA_BYTES-1:0] keep, input logic last);
        logic                  legal;
        logic [DATA_BYTES-1:0] mask;
        legal = 1'b0;
        mask  = {DATA_BYTES{1'b0}};
        if (!last) begin
            legal = (keep == {DATA_BYTES{1'b1}});
        end else begin
            for (int n = 1; n <= DATA_BYTES; n++) begin
                mask = ~({DATA_BYTES{1'b1}} >> n);
                if (keep == mask) begin
                    legal = 1'b1;
                end else begin
                    legal = legal;
                end
            end
        end
        return legal;
    endfunction

    // Lowest kept lane, i.e. the lane that is emitted last.
    function automatic logic [LANE_WIDTH-1:0] last_lane(input logic [DATA_BYTES-1:0] keep);
        logic [LANE_WIDTH-1:0] lane;
        lane = {LANE_WIDTH{1'b0}};
        for (int i = DATA_BYTES - 1; i >= 0; i--) begin
            if (keep[i]) begin
                lane = LANE_WIDTH'(i);
            end else begin
                lane = lane;
            end
        end
        return lane;
    endfunction

    function automatic logic [BYTE-1:0] lane_byte(input logic [DATA_WIDTH-1:0] data,
                                                  input logic [LANE_WIDTH-1:0] lane);
        return data[lane*BYTE +: BYTE];
    endfunction

endpackage

// File: rtl/word_to_byte_unpacker.sv
// Splits keep-qualified 32-bit words into an ordered byte stream (lane 3 first),
// reporting each packet's byte length and dropping words with illegal keep masks.
module word_to_byte_unpacker
    import stream_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] s_word_data,
    input  logic [DATA_BYTES-1:0] s_word_keep,
    input  logic                  s_word_last,
    input  logic                  s_word_valid,
    output logic                  s_word_ready,
    output logic [BYTE-1:0]       m_byte_data,
    output logic                  m_byte_last,
    output logic                  m_byte_valid,
    input  logic                  m_byte_ready,
    output logic [LEN_WIDTH-1:0]  o_pkt_len,
    output logic                  o_pkt_done,
    output logic                  o_keep_err
);

    localparam logic [LANE_WIDTH-1:0] LANE_TOP = LANE_WIDTH'(DATA_BYTES - 1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    unpack_state_e          state_r;
    logic [DATA_WIDTH-1:0]  data_r;
    logic                   last_r;
    logic [LANE_WIDTH-1:0]  lane_r;
    logic [LANE_WIDTH-1:0]  last_lane_r;
    logic [BYTE-1:0]        byte_data_r;
    logic                   byte_last_r;
    logic                   byte_valid_r;
    logic [LEN_WIDTH-1:0]   count_r;
    logic [LEN_WIDTH-1:0]   pkt_len_r;
    logic                   pkt_done_r;
    logic                   keep_err_r;

    word_t                  word_in_s;
    logic                   in_legal_s;
    logic [LANE_WIDTH-1:0]  in_last_lane_s;
    logic [LANE_WIDTH-1:0]  lane_dn_s;
    logic                   at_last_s;
    logic                   byte_fire_s;
    logic                   word_ready_s;
    logic                   word_fire_s;
    logic [LEN_WIDTH-1:0]   count_inc_s;

    // Decode the incoming word and the current serialisation position.
    always_comb begin
        word_in_s      = '{data: s_word_data, keep: s_word_keep, last: s_word_last};
        in_legal_s     = keep_legal(word_in_s.keep, word_in_s.last);
        in_last_lane_s = last_lane(word_in_s.keep);
        lane_dn_s      = lane_r - LANE_WIDTH'(1);
        at_last_s      = (lane_r == last_lane_r);
        byte_fire_s    = byte_valid_r && m_byte_ready;
        count_inc_s    = (count_r == {LEN_WIDTH{1'b1}}) ? count_r : (count_r + LEN_ONE);
    end

    // Accept a word when idle, or when the final lane leaves this cycle (back-to-back words).
    always_comb begin
        word_ready_s = 1'b0;
        if (!i_reset_n) begin
            word_ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:   word_ready_s = 1'b1;
                ST_SERIAL: word_ready_s = at_last_s && m_byte_ready;
                default:   word_ready_s = 1'b0;
            endcase
        end
        word_fire_s = s_word_valid && word_ready_s;
    end

    // Unpacking FSM, lane stepping, packet length counter and status pulses.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r      <= ST_IDLE;
            data_r       <= {DATA_WIDTH{1'b0}};
            last_r       <= 1'b0;
            lane_r       <= {LANE_WIDTH{1'b0}};
            last_lane_r  <= {LANE_WIDTH{1'b0}};
            byte_data_r  <= {BYTE{1'b0}};
            byte_last_r  <= 1'b0;
            byte_valid_r <= 1'b0;
            count_r      <= {LEN_WIDTH{1'b0}};
            pkt_len_r    <= {LEN_WIDTH{1'b0}};
            pkt_done_r   <= 1'b0;
            keep_err_r   <= 1'b0;
        end else begin
            pkt_done_r <= 1'b0;
            keep_err_r <= 1'b0;

            if (byte_fire_s) begin
                if (at_last_s && byte_last_r) begin
                    pkt_len_r  <= count_inc_s;
                    pkt_done_r <= 1'b1;
                    count_r    <= {LEN_WIDTH{1'b0}};
                end else begin
                    count_r <= count_inc_s;
                end
                if (at_last_s) begin
                    state_r      <= ST_IDLE;
                    byte_valid_r <= 1'b0;
                    byte_last_r  <= 1'b0;
                end else begin
                    lane_r      <= lane_dn_s;
                    byte_data_r <= lane_byte(data_r, lane_dn_s);
                    byte_last_r <= last_r && (lane_dn_s == last_lane_r);
                end
            end else begin
                count_r <= count_r;
            end

            // A new word overrides the idle transition taken above in the same cycle.
            if (word_fire_s) begin
                if (in_legal_s) begin
                    state_r      <= ST_SERIAL;
                    data_r       <= word_in_s.data;
                    last_r       <= word_in_s.last;
                    lane_r       <= LANE_TOP;
                    last_lane_r  <= in_last_lane_s;
                    byte_data_r  <= lane_byte(word_in_s.data, LANE_TOP);
                    byte_last_r  <= word_in_s.last && (in_last_lane_s == LANE_TOP);
                    byte_valid_r <= 1'b1;
                end else begin
                    keep_err_r <= 1'b1;
                    count_r    <= {LEN_WIDTH{1'b0}};
                end
            end else begin
                keep_err_r <= 1'b0;
            end
        end
    end

    assign s_word_ready = word_ready_s;
    assign m_byte_data  = byte_data_r;
    assign m_byte_last  = byte_last_r;
    assign m_byte_valid = byte_valid_r;
    assign o_pkt_len    = pkt_len_r;
    assign o_pkt_done   = pkt_done_r;
    assign o_keep_err   = keep_err_r;

endmodule
